// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M multiply/divide unit.
//   - OP_* : funct3 operation encodings
//   - S_*  : controller state encoding
//   - abs_n / neg_n : two's-complement helpers over a w-bit field held in a
//     MAX_W-bit container; callers pass their width (DATA_WIDTH or 2*DATA_WIDTH)
//     and truncate the result with an explicit cast.
package muldiv_pkg;

  // Container width for the helpers; covers a 2N-bit product for N <= 64.
  localparam int unsigned MAX_W = 128;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [1:0] S_SPEC = 2'd3;

  // Mask keeping the low w bits of a container.
  function automatic logic [MAX_W-1:0] width_mask(input int unsigned w);
    logic [MAX_W-1:0] m;
    m = '1;
    if (w < MAX_W) m = ~(m << w);
    return m;
  endfunction

  // Two's-complement negation of the low w bits.
  function automatic logic [MAX_W-1:0] neg_n(input logic [MAX_W-1:0] x,
                                             input int unsigned w);
    return (~x + MAX_W'(1)) & width_mask(w);
  endfunction

  // Magnitude of the low w bits read as a signed value; the most-negative
  // value maps to its unsigned magnitude 2^(w-1).
  function automatic logic [MAX_W-1:0] abs_n(input logic [MAX_W-1:0] x,
                                             input int unsigned w);
    logic [MAX_W-1:0] t;
    t = (x >> (w - 1)) & MAX_W'(1);
    return (t != '0) ? neg_n(x, w) : (x & width_mask(w));
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle.
// Multiply is radix-2 shift-add, divide is restoring; both share one 2N-bit
// shift register and one counter. Divide-by-zero and signed overflow skip the
// iteration and complete one edge after acceptance.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            clock enable; low freezes all state and ignores start
//   start         request, accepted when en && !busy
//   control[2:0]  funct3 op (MUL..REMU)
//   srca, srcb    rs1 / rs2 operands
//   busy          high from the edge after acceptance until the result edge
//   done          pulse marking y valid (stretched while en is low)
//   y             result, held between completions
//   zero          y == 0 (combinational from y)
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  start,
  input  logic [2:0]            control,
  input  logic [DATA_WIDTH-1:0] srca,
  input  logic [DATA_WIDTH-1:0] srcb,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] y,
  output logic                  zero
);

  localparam int unsigned N  = DATA_WIDTH;
  localparam int unsigned W2 = 2 * DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);

  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);
  localparam logic [N-1:0]  MOST_NEG  = {1'b1, {(N-1){1'b0}}};

  logic [1:0]    state, state_nxt;
  logic [2:0]    op_q, op_nxt;
  logic          sign_q, sign_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic [W2-1:0] acc_q, acc_nxt;
  logic [N-1:0]  opb_q, opb_nxt;
  logic          busy_nxt, done_nxt;
  logic [N-1:0]  y_nxt;

  logic          is_div, a_signed, b_signed, sa, sb, div_zero, div_ovf;
  logic [N-1:0]  abs_a, abs_b, spec_y;
  logic [N:0]    mul_sum, div_sh, div_trial;
  logic [W2-1:0] prod_fix;
  logic [N-1:0]  quo_fix, rem_fix, fin_y;

  // Operand decode at acceptance: signedness, magnitudes, special cases.
  always_comb begin
    is_div   = control[2];
    a_signed = (control == OP_MUL) || (control == OP_MULH) ||
               (control == OP_MULHSU) || (control == OP_DIV) ||
               (control == OP_REM);
    b_signed = (control == OP_MUL) || (control == OP_MULH) ||
               (control == OP_DIV) || (control == OP_REM);
    sa       = a_signed & srca[N-1];
    sb       = b_signed & srcb[N-1];
    abs_a    = a_signed ? N'(abs_n(MAX_W'(srca), N)) : srca;
    abs_b    = b_signed ? N'(abs_n(MAX_W'(srcb), N)) : srcb;
    div_zero = is_div && (srcb == '0);
    div_ovf  = ((control == OP_DIV) || (control == OP_REM)) &&
               (srca == MOST_NEG) && (srcb == '1);
    // control[1] distinguishes REM/REMU from DIV/DIVU.
    if (div_zero) spec_y = control[1] ? srca : '1;
    else          spec_y = control[1] ? '0 : srca;
  end

  // One iteration step for each algorithm plus the final sign fix-up.
  always_comb begin
    // Multiply: {hi, lo} with lo holding the remaining multiplier bits.
    mul_sum   = {1'b0, acc_q[W2-1:N]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    // Divide: {rem, quo}; shift in the next dividend bit and trial-subtract.
    div_sh    = {acc_q[W2-1:N], acc_q[N-1]};
    div_trial = div_sh - {1'b0, opb_q};
    prod_fix  = sign_q ? W2'(neg_n(MAX_W'(acc_q), W2)) : acc_q;
    quo_fix   = sign_q ? N'(neg_n(MAX_W'(acc_q[N-1:0]), N)) : acc_q[N-1:0];
    rem_fix   = sign_q ? N'(neg_n(MAX_W'(acc_q[W2-1:N]), N)) : acc_q[W2-1:N];
    if (op_q[2])              fin_y = op_q[1] ? rem_fix : quo_fix;
    else if (op_q == OP_MUL)  fin_y = prod_fix[N-1:0];
    else                      fin_y = prod_fix[W2-1:N];
  end

  // Controller and datapath next-state.
  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    sign_nxt  = sign_q;
    cnt_nxt   = cnt_q;
    acc_nxt   = acc_q;
    opb_nxt   = opb_q;
    busy_nxt  = busy;
    done_nxt  = 1'b0;
    y_nxt     = y;

    case (state)
      S_IDLE: begin
        if (start) begin
          op_nxt   = control;
          // Remainder follows the dividend's sign; everything else a^b.
          sign_nxt = (control == OP_REM) ? sa : (sa ^ sb);
          cnt_nxt  = '0;
          busy_nxt = 1'b1;
          if (div_zero || div_ovf) begin
            acc_nxt   = W2'(spec_y);
            state_nxt = S_SPEC;
          end else begin
            state_nxt = S_CALC;
            if (is_div) begin
              acc_nxt = {{N{1'b0}}, abs_a};
              opb_nxt = abs_b;
            end else begin
              acc_nxt = {{N{1'b0}}, abs_b};
              opb_nxt = abs_a;
            end
          end
        end
      end

      S_CALC: begin
        cnt_nxt = cnt_q + CW'(1);
        if (op_q[2]) begin
          // Negative trial result means restore (keep the shifted remainder).
          if (div_trial[N]) acc_nxt = {div_sh[N-1:0], acc_q[N-2:0], 1'b0};
          else              acc_nxt = {div_trial[N-1:0], acc_q[N-2:0], 1'b1};
        end else begin
          acc_nxt = {mul_sum, acc_q[N-1:1]};
        end
        if (cnt_q == LAST_ITER) state_nxt = S_FIN;
      end

      S_FIN: begin
        y_nxt     = fin_y;
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        cnt_nxt   = '0;
        state_nxt = S_IDLE;
      end

      S_SPEC: begin
        y_nxt     = acc_q[N-1:0];
        done_nxt  = 1'b1;
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end

      default: begin
        busy_nxt  = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State register; reset overrides the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      op_q   <= '0;
      sign_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      opb_q  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      y      <= '0;
    end else if (en) begin
      state  <= state_nxt;
      op_q   <= op_nxt;
      sign_q <= sign_nxt;
      cnt_q  <= cnt_nxt;
      acc_q  <= acc_nxt;
      opb_q  <= opb_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
      y      <= y_nxt;
    end
  end

  assign zero = (y == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (N = 32): directed cases, control
// disturbances and randomized operations against an arithmetic reference model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, start;
  logic [2:0]  control;
  logic [31:0] srca, srcb, y;
  logic        busy, done, zero;

  int n_pass   = 0;
  int n_total  = 0;
  int cyc      = 0;
  int t0       = 0;
  int busy_gap = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .control(control),
    .srca(srca), .srcb(srcb), .busy(busy), .done(done), .y(y), .zero(zero)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Reference results straight from the RV32M definitions.
  function automatic logic [31:0] ref_y(input logic [2:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    int          sa, sb;
    longint      ps;
    logic [63:0] pu;
    logic [31:0] r;
    sa = a;
    sb = b;
    r  = '0;
    case (op)
      OP_MUL:    r = a * b;
      OP_MULH:   begin ps = longint'(sa) * longint'(sb); r = ps[63:32]; end
      OP_MULHSU: begin ps = longint'(sa) * longint'({32'd0, b}); r = ps[63:32]; end
      OP_MULHU:  begin pu = {32'd0, a} * {32'd0, b}; r = pu[63:32]; end
      OP_DIV:    if (b == 0) r = '1;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                 else r = sa / sb;
      OP_DIVU:   r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:    if (b == 0) r = a;
                 else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = '0;
                 else r = sa % sb;
      default:   r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    if (op[2] && b == 0) return 1;
    if ((op == OP_DIV || op == OP_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return 1;
    return 33;
  endfunction

  // Present a request for one cycle; t0 marks the acceptance edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    control = op; srca = a; srcb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    t0    = cyc;
    srca  = $urandom;
    srcb  = $urandom;
    check_eq("busy_after_accept", 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      if (busy !== 1'b1) busy_gap++;
      @(posedge clk); #1;
      k++;
    end
    check_eq("done_seen", 32'(done), 32'd1);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat);
    issue(op, a, b);
    wait_done(100);
    check_eq($sformatf("y op%0d %h,%h", op, a, b), y, exp);
    check_eq($sformatf("latency op%0d", op), 32'(cyc - t0), 32'(exp_lat));
    check_eq("busy_at_done", 32'(busy), 32'd0);
    check_eq("zero_flag", 32'(zero), 32'(exp == 0));
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  logic [2:0]  d_op  [14] = '{OP_MUL, OP_MULH, OP_MULHU, OP_MULHSU, OP_DIV, OP_REM,
                              OP_DIVU, OP_REMU, OP_DIVU, OP_REM, OP_DIV, OP_REM,
                              OP_MUL, OP_DIV};
  logic [31:0] d_a   [14] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5,
                              32'd5, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'hFFFF_FFF9};
  logic [31:0] d_b   [14] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF,
                              32'hFFFF_FFFF, 32'h1234_5678, 32'd0};
  logic [31:0] d_y   [14] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                              32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF,
                              32'd5, 32'h8000_0000, 32'd0, 32'd0, 32'hFFFF_FFFF};
  int          d_lat [14] = '{33, 33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1, 33, 1};

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, held;

    rst = 1'b1; en = 1'b1; start = 1'b0; control = '0; srca = '0; srcb = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_done", 32'(done), 32'd0);
    check_eq("reset_y", y, 32'd0);
    check_eq("reset_zero", 32'(zero), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases from the RV32M definitions, issued back-to-back.
    for (int i = 0; i < 14; i++) run_op(d_op[i], d_a[i], d_b[i], d_y[i], d_lat[i]);

    // done stretches while en is low and clears on the next enabled edge.
    run_op(OP_DIVU, 32'd1000, 32'd3, 32'd333, 33);
    @(negedge clk); en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("done_held_en_low", 32'(done), 32'd1);
    check_eq("y_held_en_low", y, 32'd333);
    @(negedge clk); en = 1'b1;
    @(posedge clk); #1;
    check_eq("done_cleared", 32'(done), 32'd0);
    check_eq("y_stable_idle", y, 32'd333);

    // start with new operands mid-divide is ignored.
    issue(OP_DIV, 32'd1000, 32'd7);
    repeat (9) @(posedge clk);
    @(negedge clk);
    control = OP_MUL; srca = 32'd5; srcb = 32'd6; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100);
    check_eq("busy_start_ignored_y", y, 32'd142);
    check_eq("busy_start_ignored_lat", 32'(cyc - t0), 32'd33);

    // en low for 5 cycles mid-CALC delays done by 5 edges.
    issue(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678);
    repeat (10) @(posedge clk);
    @(negedge clk); en = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); en = 1'b1;
    wait_done(100);
    check_eq("en_stall_y", y, ref_y(OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678));
    check_eq("en_stall_lat", 32'(cyc - t0), 32'd38);

    // Reset mid-multiply aborts; an op one cycle later runs normally.
    issue(OP_MUL, 32'h1234, 32'h5678);
    repeat (14) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_done", 32'(done), 32'd0);
    check_eq("abort_y", y, 32'd0);
    @(negedge clk); rst = 1'b0;
    run_op(OP_MUL, 32'd3, 32'd5, 32'd15, 33);

    // Randomized operations against the reference model.
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      run_op(op, a, b, ref_y(op, a, b), ref_lat(op, a, b));
    end

    held = y;
    repeat (4) @(posedge clk);
    #1;
    check_eq("y_stable_end", y, held);
    check_eq("busy_gap", 32'(busy_gap), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
